// File: rtl/pipe_hazard_ctrl.sv
// Front-end stall/flush controller: stall and flush generation for NUM_STAGES
// in-order stages, post-redirect refill window, stall watchdog, perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REFILL_CYC = 1,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned LVL_W     = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_en,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] flush_req,
    input  logic                  perf_clr,
    output logic [NUM_STAGES-1:0] stage_stall,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  pc_redirect,
    output logic [LVL_W-1:0]      redirect_lvl,
    output logic                  allocate_en,
    output logic                  refill,
    output logic                  deadlock,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int unsigned RF_W = (REFILL_CYC > 1) ? $clog2(REFILL_CYC + 1) : 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        RUN,
        REFILL
    } state_e;

    state_e            state_q, state_d;
    logic [RF_W-1:0]   rcnt_q, rcnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              deadlock_q, deadlock_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic [NUM_STAGES-1:0] flush_or;
    logic [NUM_STAGES-1:0] stall_or;

    // Suffix ORs: a request at stage k affects every stage j <= k.
    for (genvar j = 0; j < NUM_STAGES; j++) begin : g_suffix
        assign flush_or[j] = |flush_req[NUM_STAGES-1:j];
        assign stall_or[j] = |stall_req[NUM_STAGES-1:j];
    end

    always_comb begin
        pc_redirect  = flush_or[0];
        stage_flush  = {flush_or[NUM_STAGES-1:1], 1'b0};
        // flush_or[0] equals pc_redirect, so one mask covers stage 0 as well
        stage_stall  = stall_or & ~flush_or;
        redirect_lvl = '0;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            if (flush_req[k]) begin
                redirect_lvl = LVL_W'(k);
            end
        end
    end

    assign refill      = (state_q == REFILL);
    assign allocate_en = rst_n & if_en & ~stage_stall[NUM_STAGES-1] & ~refill & ~pc_redirect;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            RUN: begin
                if (pc_redirect && (REFILL_CYC > 0)) begin
                    state_d = REFILL;
                    rcnt_d  = RF_W'(REFILL_CYC);
                end
            end
            REFILL: begin
                if (pc_redirect) begin
                    rcnt_d = RF_W'(REFILL_CYC);
                end else if (rcnt_q == RF_W'(1)) begin
                    state_d = RUN;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                rcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        wd_d           = '0;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stage_stall[0]) begin
            wd_d = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
            if (stall_cycles_q != '1) begin
                stall_cycles_d = stall_cycles_q + 1'b1;
            end
        end
        if (pc_redirect && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
        deadlock_d = deadlock_q | (wd_d == WD_W'(TIMEOUT));
        if (perf_clr) begin
            wd_d           = '0;
            deadlock_d     = 1'b0;
            stall_cycles_d = '0;
            flush_count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            rcnt_q         <= '0;
            wd_q           <= '0;
            deadlock_q     <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            rcnt_q         <= rcnt_d;
            wd_q           <= wd_d;
            deadlock_q     <= deadlock_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign deadlock     = deadlock_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised front-end stall/flush controller for the OoO core; successor to the fixed PC/IF/ID controller.
- Generalises stall and flush to NUM_STAGES in-order front-end stages (stage 0 = PC, 1 = IF, 2 = ID, ...).
- Adds a post-redirect refill window, a stall watchdog and saturating performance counters.
- Sits between front-end stage registers and hazard sources: ROB full, issue queue full, decoder operand wait, jump/branch redirects.

Parameters:
NUM_STAGES, 3, number of front-end stages including PC (>=2)
REFILL_CYC, 1, cycles allocate_en is held low after a redirect (0 = disabled)
TIMEOUT, 1024, consecutive stage-0 stall cycles before deadlock is flagged (>=1)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
if_en  in  1  fetch enable
stall_req  in  NUM_STAGES  stall_req[k]: stage k cannot advance
flush_req  in  NUM_STAGES  flush_req[k]: redirect PC and kill stages 1..k
perf_clr  in  1  synchronous clear of counters and deadlock flag
stage_stall  out  NUM_STAGES  hold enable per stage
stage_flush  out  NUM_STAGES  kill per stage (bit 0 always 0)
pc_redirect  out  1  PC loads redirect target this cycle
redirect_lvl  out  clog2(NUM_STAGES)  index of the winning flush_req
allocate_en  out  1  ROB/rename allocation permitted
refill  out  1  refill window active
deadlock  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  saturating count of stage-0 stall cycles
flush_count  out  CNT_W  saturating count of redirects

Behaviour:
- Combinational outputs, evaluated from the current inputs and state:
  - pc_redirect = |flush_req.
  - redirect_lvl = highest k with flush_req[k] set; 0 when pc_redirect is low. The highest level wins on simultaneous requests.
  - stage_flush[j] (j>=1) = OR of flush_req[k] for k>=j. stage_flush[0] = 0.
  - stage_stall[j] = OR of stall_req[k] for k>=j (back-pressure propagates upstream), masked by stage_flush[j]. stage_stall[0] is masked by pc_redirect. Flush overrides stall.
  - allocate_en = if_en & ~stage_stall[NUM_STAGES-1] & ~refill & ~pc_redirect.
- Refill FSM:
  - States: RUN, REFILL.
  - RUN -> REFILL when pc_redirect=1 and REFILL_CYC>0. The counter loads REFILL_CYC.
  - In REFILL: the counter decrements each cycle not under redirect. The FSM returns to RUN in the cycle after the counter reaches 1.
  - A new redirect in REFILL reloads the counter to REFILL_CYC.
  - refill = (state==REFILL).
  - With REFILL_CYC=0 the FSM stays in RUN.
- Watchdog:
  - A consecutive-stall counter increments while stage_stall[0]=1 and clears when stage_stall[0]=0.
  - deadlock sets in the cycle the counter reaches TIMEOUT. It stays set until perf_clr or reset.
  - The counter saturates at TIMEOUT.
- Counters:
  - stall_cycles increments each cycle stage_stall[0]=1.
  - flush_count increments each cycle pc_redirect=1.
  - Both saturate at all-ones.
  - perf_clr zeroes stall_cycles, flush_count, the watchdog counter and deadlock in the next cycle. The current cycle's increment is discarded.
- Reset:
  - Asynchronous: state=RUN, refill=0, all counters and deadlock=0.
  - Reset mid-refill aborts the window immediately.
  - Combinational outputs follow their inputs during reset. allocate_en is forced to 0 while rst_n=0.

Test Plan:
- NUM_STAGES=3, stall_req=3'b100, if_en=1 -> stage_stall=3'b111, allocate_en=0; stall_req=3'b010 -> stage_stall=3'b011, allocate_en=1.
- flush_req=3'b010 with stall_req=3'b011 -> stage_flush=3'b010, stage_stall=3'b000, pc_redirect=1, redirect_lvl=1; next cycle refill=1, allocate_en=0; following cycle refill=0 (REFILL_CYC=1).
- flush_req=3'b110 -> redirect_lvl=2, stage_flush=3'b110; REFILL_CYC=3 with a second redirect 2 cycles later -> refill high for 3 cycles after the second redirect.
- TIMEOUT=8, stall_req[0]=1 held for 8 cycles -> deadlock=1 in cycle 8, stall_cycles=8; release the stall -> deadlock stays 1; perf_clr -> deadlock=0 and stall_cycles=0 the next cycle.
- CNT_W=4, 20 single-cycle redirects -> flush_count saturates at 15.
- rst_n low during REFILL -> refill=0 and counters=0 asynchronously; after release, allocate_en=1 when if_en=1 and there are no stalls.
